// File: rtl/slc3_instr_decoder.sv
// SLC-3 registered instruction-decode stage: one word per cycle in, decoded fields out one cycle later.
// Optional build macro SLC3_DEC_STATS_EN adds the hand-off counter behind out_instr_cnt.
module slc3_instr_decoder #(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_opcode,
  output logic [9:0]           out_kind,
  output logic [2:0]           out_dr,
  output logic [2:0]           out_sr1,
  output logic [2:0]           out_sr2,
  output logic                 out_imm_sel,
  output logic [2:0]           out_nzp,
  output logic [15:0]          out_imm16,
  output logic                 out_nop,
  output logic                 out_ret,
  output logic [ILL_CNT_W-1:0] out_ill_cnt,
  output logic [15:0]          out_instr_cnt
);

  localparam int K_ADD = 0;
  localparam int K_AND = 1;
  localparam int K_NOT = 2;
  localparam int K_BR  = 3;
  localparam int K_JMP = 4;
  localparam int K_JSR = 5;
  localparam int K_LDR = 6;
  localparam int K_STR = 7;
  localparam int K_PSE = 8;
  localparam int K_ILL = 9;

  // Handshake: a word transfers on any rising edge where valid & ready are both
  // high; valid never waits on ready, and the output side holds while blocked.
  logic accept;
  logic handoff;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign handoff  = out_valid & out_ready;

  logic [9:0]  d_kind;
  logic [2:0]  d_dr;
  logic [2:0]  d_sr1;
  logic [2:0]  d_sr2;
  logic        d_imm_sel;
  logic [2:0]  d_nzp;
  logic [15:0] d_imm16;
  logic        d_nop;
  logic        d_ret;

  always_comb begin
    d_kind    = '0;
    d_dr      = in_instr[11:9];
    d_sr1     = in_instr[8:6];
    d_sr2     = in_instr[2:0];
    d_imm_sel = 1'b0;
    d_nzp     = 3'b000;
    d_imm16   = 16'h0000;
    d_nop     = 1'b0;
    d_ret     = 1'b0;
    case (in_instr[15:12])
      4'b0001, 4'b0101: begin
        d_kind[K_ADD] = (in_instr[15:12] == 4'b0001);
        d_kind[K_AND] = (in_instr[15:12] == 4'b0101);
        d_imm_sel     = in_instr[5];
        if (in_instr[5]) d_imm16 = {{11{in_instr[4]}}, in_instr[4:0]};
      end
      4'b1001: d_kind[K_NOT] = 1'b1;
      4'b0000: begin
        d_kind[K_BR] = 1'b1;
        d_nzp        = in_instr[11:9];
        d_imm16      = {{7{in_instr[8]}}, in_instr[8:0]};
        d_nop        = (in_instr[11:9] == 3'b000);
      end
      4'b1100: begin
        d_kind[K_JMP] = 1'b1;
        d_ret         = (in_instr[8:6] == 3'b111);
      end
      4'b0100: begin
        // JSRR (bit 11 clear) is not part of the SLC-3 subset.
        if (in_instr[11]) begin
          d_kind[K_JSR] = 1'b1;
          d_imm16       = {{5{in_instr[10]}}, in_instr[10:0]};
        end else begin
          d_kind[K_ILL] = 1'b1;
        end
      end
      4'b0110, 4'b0111: begin
        d_kind[K_LDR] = (in_instr[15:12] == 4'b0110);
        d_kind[K_STR] = (in_instr[15:12] == 4'b0111);
        d_imm16       = {{10{in_instr[5]}}, in_instr[5:0]};
      end
      4'b1101: begin
        d_kind[K_PSE] = 1'b1;
        d_imm16       = {4'h0, in_instr[11:0]};
      end
      default: d_kind[K_ILL] = 1'b1;
    endcase
    if (d_kind[K_ILL]) begin
      d_dr  = 3'b000;
      d_sr1 = 3'b000;
      d_sr2 = 3'b000;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      out_valid   <= 1'b0;
      out_opcode  <= 4'h0;
      out_kind    <= '0;
      out_dr      <= 3'b000;
      out_sr1     <= 3'b000;
      out_sr2     <= 3'b000;
      out_imm_sel <= 1'b0;
      out_nzp     <= 3'b000;
      out_imm16   <= 16'h0000;
      out_nop     <= 1'b0;
      out_ret     <= 1'b0;
      out_ill_cnt <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_opcode  <= in_instr[15:12];
      out_kind    <= d_kind;
      out_dr      <= d_dr;
      out_sr1     <= d_sr1;
      out_sr2     <= d_sr2;
      out_imm_sel <= d_imm_sel;
      out_nzp     <= d_nzp;
      out_imm16   <= d_imm16;
      out_nop     <= d_nop;
      out_ret     <= d_ret;
      if (d_kind[K_ILL] && (out_ill_cnt != '1)) out_ill_cnt <= out_ill_cnt + ILL_CNT_W'(1);
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SLC3_DEC_STATS_EN
  logic [15:0] instr_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) instr_cnt_q <= 16'h0000;
    else if (handoff) instr_cnt_q <= instr_cnt_q + 16'd1;
  end

  assign out_instr_cnt = instr_cnt_q;
`else
  assign out_instr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_slc3_instr_decoder.sv
// Bench for slc3_instr_decoder: directed words, expected fields queued on accept, compared by a monitor on output.
module tb_slc3_instr_decoder;
  localparam int ILLW = 2;
  localparam int EW   = 47;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_opcode;
  logic [9:0]  out_kind;
  logic [2:0]  out_dr, out_sr1, out_sr2, out_nzp;
  logic        out_imm_sel, out_nop, out_ret;
  logic [15:0] out_imm16;
  logic [ILLW-1:0] out_ill_cnt;
  logic [15:0] out_instr_cnt;

  logic [EW-1:0]   exp_q[$];
  logic [ILLW-1:0] ill_m = '0;
  int checks = 0, errors = 0, handoffs = 0, n_pushed = 0, stalls = 0;
  bit mon_en = 1'b0;

  slc3_instr_decoder #(.ILL_CNT_W(ILLW)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_kind(out_kind),
    .out_dr(out_dr), .out_sr1(out_sr1), .out_sr2(out_sr2), .out_imm_sel(out_imm_sel),
    .out_nzp(out_nzp), .out_imm16(out_imm16), .out_nop(out_nop), .out_ret(out_ret),
    .out_ill_cnt(out_ill_cnt), .out_instr_cnt(out_instr_cnt)
  );

  // clock / reset block
  always #5 Clk = ~Clk;

  function automatic logic [44:0] ex(input logic [3:0] op, input logic [9:0] kind,
                                     input logic [2:0] dr, input logic [2:0] sr1, input logic [2:0] sr2,
                                     input logic imm_sel, input logic [2:0] nzp, input logic [15:0] imm,
                                     input logic nop, input logic ret);
    return {op, kind, dr, sr1, sr2, imm_sel, nzp, imm, nop, ret};
  endfunction

  function automatic logic [44:0] ill(input logic [3:0] op);
    return ex(op, 10'h200, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // driver: present one word, wait for it to be taken, queue its expected fields
  task automatic send(input logic [15:0] instr, input logic [44:0] e);
    int waited;
    logic rdy;
    waited = 0;
    rdy = 1'b0;
    @(negedge Clk);
    in_valid = 1'b1;
    in_instr = instr;
    forever begin
      #4;
      rdy = in_ready;
      @(posedge Clk);
      if (rdy) break;
      stalls++;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout instr=%h actual=no_accept required=accept", instr);
        break;
      end
      @(negedge Clk);
    end
    if (rdy) begin
      if (e[40] && ill_m != '1) ill_m = ill_m + 1'b1;
      exp_q.push_back({ill_m, e});
      n_pushed++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge Clk);
    check("drain_queue", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stats_check();
    @(negedge Clk);
    #4;
`ifdef SLC3_DEC_STATS_EN
    check("instr_cnt", 64'(out_instr_cnt), 64'(n_pushed));
`else
    check("instr_cnt", 64'(out_instr_cnt), 64'd0);
`endif
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge Clk);
      #4;
      if (mon_en) begin
        check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=opcode_%h required=none", out_opcode);
          end else begin
            check("decode", 64'({out_ill_cnt, out_opcode, out_kind, out_dr, out_sr1, out_sr2, out_imm_sel,
                                 out_nzp, out_imm16, out_nop, out_ret}), 64'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
              handoffs++;
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #4;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_kind", 64'(out_kind), 64'd0);
    check("rst_fields", 64'({out_opcode, out_dr, out_sr1, out_sr2, out_imm_sel, out_nzp, out_imm16, out_nop, out_ret}), 64'd0);
    check("rst_ill_cnt", 64'(out_ill_cnt), 64'd0);
    check("rst_instr_cnt", 64'(out_instr_cnt), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    Reset = 1'b1;
    mon_en = 1'b1;

    h0 = handoffs;
    send(16'h12BD, ex(4'h1, 10'h001, 3'd1, 3'd2, 3'd5, 1'b1, 3'd0, 16'hFFFD, 1'b0, 1'b0));
    send(16'h5A3F, ex(4'h5, 10'h002, 3'd5, 3'd0, 3'd7, 1'b1, 3'd0, 16'hFFFF, 1'b0, 1'b0));
    send(16'h5643, ex(4'h5, 10'h002, 3'd3, 3'd1, 3'd3, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
    send(16'h967F, ex(4'h9, 10'h004, 3'd3, 3'd1, 3'd7, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
    check("no_bubble", 64'(handoffs), 64'(h0 + 3));
    send(16'h0FFF, ex(4'h0, 10'h008, 3'd7, 3'd7, 3'd7, 1'b0, 3'd7, 16'hFFFF, 1'b0, 1'b0));
    send(16'h0000, ex(4'h0, 10'h008, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0));
    send(16'h05FE, ex(4'h0, 10'h008, 3'd2, 3'd7, 3'd6, 1'b0, 3'd2, 16'hFFFE, 1'b0, 1'b0));
    send(16'h4C00, ex(4'h4, 10'h020, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 16'hFC00, 1'b0, 1'b0));
    send(16'hC1C0, ex(4'hC, 10'h010, 3'd0, 3'd7, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1));
    send(16'hC080, ex(4'hC, 10'h010, 3'd0, 3'd2, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0));
    send(16'hD801, ex(4'hD, 10'h100, 3'd4, 3'd0, 3'd1, 1'b0, 3'd0, 16'h0801, 1'b0, 1'b0));
    send(16'h6A3F, ex(4'h6, 10'h040, 3'd5, 3'd0, 3'd7, 1'b0, 3'd0, 16'hFFFF, 1'b0, 1'b0));
    send(16'h7E60, ex(4'h7, 10'h080, 3'd7, 3'd1, 3'd0, 1'b0, 3'd0, 16'hFFE0, 1'b0, 1'b0));
    send(16'h1E2F, ex(4'h1, 10'h001, 3'd7, 3'd0, 3'd7, 1'b1, 3'd0, 16'h000F, 1'b0, 1'b0));
    send(16'hDFFF, ex(4'hD, 10'h100, 3'd7, 3'd7, 3'd7, 1'b0, 3'd0, 16'h0FFF, 1'b0, 1'b0));
    send(16'h4BFF, ex(4'h4, 10'h020, 3'd5, 3'd7, 3'd7, 1'b0, 3'd0, 16'h03FF, 1'b0, 1'b0));

    // illegal words, counter saturates at 3 with a 2-bit width
    send(16'h8000, ill(4'h8));
    send(16'h4000, ill(4'h4));
    send(16'hA123, ill(4'hA));
    send(16'hBFFF, ill(4'hB));
    send(16'h2345, ill(4'h2));
    drain();
    stats_check();
    check("ill_cnt_sat", 64'(out_ill_cnt), 64'd3);

    stalls = 0;
    fork
      begin
        send(16'h12BD, ex(4'h1, 10'h001, 3'd1, 3'd2, 3'd5, 1'b1, 3'd0, 16'hFFFD, 1'b0, 1'b0));
        send(16'h0000, ex(4'h0, 10'h008, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0));
        send(16'hC1C0, ex(4'hC, 10'h010, 3'd0, 3'd7, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1));
        send(16'h6A3F, ex(4'h6, 10'h040, 3'd5, 3'd0, 3'd7, 1'b0, 3'd0, 16'hFFFF, 1'b0, 1'b0));
      end
      begin
        @(negedge Clk);
        @(negedge Clk);
        out_ready = 1'b0;
        repeat (3) @(negedge Clk);
        out_ready = 1'b1;
      end
    join
    check("bp_in_ready_drop", 64'(stalls != 0), 64'd1);
    drain();
    stats_check();

    // reset while a word is pending, with an illegal word offered during reset
    @(negedge Clk);
    out_ready = 1'b0;
    send(16'h1E2F, ex(4'h1, 10'h001, 3'd7, 3'd0, 3'd7, 1'b1, 3'd0, 16'h000F, 1'b0, 1'b0));
    @(negedge Clk);
    Reset = 1'b0;
    in_valid = 1'b1;
    in_instr = 16'h8000;
    @(posedge Clk);
    exp_q.delete();
    ill_m = '0;
    n_pushed = 0;
    @(negedge Clk);
    #4;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_kind", 64'(out_kind), 64'd0);
    check("mid_rst_ill_cnt", 64'(out_ill_cnt), 64'd0);
    check("mid_rst_instr_cnt", 64'(out_instr_cnt), 64'd0);
    @(negedge Clk);
    #4;
    check("rst_accept_blocked", 64'({out_valid, out_ill_cnt}), 64'd0);
    Reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(16'h12BD, ex(4'h1, 10'h001, 3'd1, 3'd2, 3'd5, 1'b1, 3'd0, 16'hFFFD, 1'b0, 1'b0));
    send(16'h4C00, ex(4'h4, 10'h020, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 16'hFC00, 1'b0, 1'b0));
    send(16'hD801, ex(4'hD, 10'h100, 3'd4, 3'd0, 3'd1, 1'b0, 3'd0, 16'h0801, 1'b0, 1'b0));
    send(16'h8000, ill(4'h8));
    drain();
    stats_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slc3_instr_decoder.md
# slc3_instr_decoder

Registered instruction-decode stage for the SLC-3 datapath: it is the consumer of the 16-bit instruction words produced by the team's SLC-3 opcode-encoding package. Accepts one raw instruction word per cycle on a valid/ready handshake and splits it into opcode class, register fields, branch condition and a sign-extended immediate. Presents the result one cycle later on a registered output handshake that holds under backpressure. Sits between the instruction register / memory fetch path and the control FSM, and doubles as a bench-side disassembler for test-memory images.

## Interface
Parameters:
- ILL_CNT_W, 8: width of the saturating illegal-instruction counter.

Ports:
- Clk  in  1  system clock; every flop is on the rising edge.
- Reset  in  1  synchronous reset, active-low; sampled on the Clk rising edge.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  stage can accept a word this cycle.
- in_instr  in  16  raw SLC-3 instruction.
- out_valid  out  1  decoded fields are valid.
- out_ready  in  1  consumer accepts the fields this cycle.
- out_opcode  out  4  raw bits [15:12].
- out_kind  out  10  one-hot: [0]ADD [1]AND [2]NOT [3]BR [4]JMP [5]JSR [6]LDR [7]STR [8]PSE [9]ILLEGAL.
- out_dr  out  3  bits [11:9]: DR, or SR for STR.
- out_sr1  out  3  bits [8:6]: SR1 or BaseR.
- out_sr2  out  3  bits [2:0].
- out_imm_sel  out  1  bit 5 for ADD/AND; 0 for every other kind.
- out_nzp  out  3  bits [11:9] for BR; 0 for every other kind.
- out_imm16  out  16  immediate, formed per kind (see Operation).
- out_nop  out  1  BR with nzp = 000.
- out_ret  out  1  JMP with BaseR = R7.
- out_ill_cnt  out  ILL_CNT_W  number of illegal words accepted.
- out_instr_cnt  out  16  number of words handed off (see Configuration).

## Operation
- Single output register stage, with no FSM beyond the valid bit. Accept occurs when in_valid & in_ready. Hand-off occurs when out_valid & out_ready.
- in_ready = ~out_valid | out_ready. This is combinational from out_ready and gives full throughput (one word per cycle) under continuous ready.
- On accept, all decoded fields load from in_instr and out_valid is set to 1.
- On hand-off without a simultaneous accept, out_valid clears to 0. Field registers keep their last value.
- While out_valid = 1 and out_ready = 0, every output is held stable.
- Opcode map: 0001 ADD, 0101 AND, 1001 NOT, 0000 BR, 1100 JMP, 0100 JSR, 0110 LDR, 0111 STR, 1101 PSE.
- Any other opcode is ILLEGAL. JSR with bit 11 = 0 (JSRR form) is also ILLEGAL.
- No other bit-level checks are made; for example, the NOT low bits are ignored.
- out_imm16 formation:
  - ADD/AND with bit 5 = 1: SEXT(bits[4:0]). With bit 5 = 0: 0.
  - LDR/STR: SEXT(bits[5:0]).
  - BR: SEXT(bits[8:0]).
  - JSR: SEXT(bits[10:0]).
  - PSE: ZEXT(bits[11:0]).
  - NOT, JMP, ILLEGAL: 0.
- For an ILLEGAL word, only out_opcode and out_kind[9] are meaningful. All other fields are 0.
- out_ill_cnt increments on each accept of an ILLEGAL word and saturates at all-ones.

## Timing
- Latency: a word accepted at edge N appears on the outputs after edge N, so out_valid is high in cycle N+1.
- Reset low at an edge: out_valid=0, all field outputs 0, out_kind=0, out_ill_cnt=0, out_instr_cnt=0.
  - in_ready reads 1 (since out_valid=0), but the accept is suppressed while Reset is low.
  - Reset mid-transfer drops the pending word with no hand-off.
- Simultaneous hand-off and accept in one cycle: the new word loads and out_valid stays 1 (no bubble).
- Counter saturation: at all-ones, a further illegal accept leaves out_ill_cnt unchanged.
- in_instr is don't-care when in_valid = 0.

## Configuration
- SLC3_DEC_STATS_EN defined: out_instr_cnt increments on every hand-off and wraps from 0xFFFF to 0x0000.
- SLC3_DEC_STATS_EN undefined: out_instr_cnt is tied to 0 and no counter flops are built.
- Decode behaviour is identical in both builds.

## Test plan
- ADDi R1,R2,#-3: accept 0x12BD -> next cycle out_kind[0]=1, dr=1, sr1=2, imm_sel=1, imm16=0xFFFD.
- BR nzp,#-1 then BR never: 0x0FFF -> nzp=7, imm16=0xFFFF, nop=0. 0x0000 -> nop=1, imm16=0x0000.
- JSR #-1024, then RET, then PSE:
  - 0x4C00 -> kind[5], imm16=0xFC00.
  - 0xC1C0 -> kind[4], ret=1.
  - 0xD801 -> kind[8], imm16=0x0801.
- Illegal: 0x8000 (RTI) and 0x4000 (JSRR) -> kind[9]=1 for each, other fields 0, out_ill_cnt=2.
  - With ILL_CNT_W=2, a further 3 illegal words leave out_ill_cnt at 3.
- Backpressure: stream 4 words with out_ready low for 3 cycles mid-stream:
  - in_ready drops, outputs stay stable, no word is lost or duplicated.
  - Back-to-back hand-off+accept produces no bubble.
  - With SLC3_DEC_STATS_EN, out_instr_cnt=4.
- Reset mid-stream: drive Reset low while out_valid=1 -> next cycle out_valid=0 and both counters read 0. The first word accepted after release decodes correctly.
